scoreboard_clear_arbiter: RTL

- Shares a small number of register-file write/scoreboard-clear ports among several long-latency result sources (remote load return, FPU, int divider, ...).
- Each cycle it grants up to num_port_p requesters in round-robin order and never grants two requesters with the same destination id in one cycle.
- Granted results are registered for one cycle, then driven to the RF write ports and the scoreboard clear ports.
- Sits between the long-latency units and the vanilla core's RF/scoreboard.

---
 rtl/scoreboard_clear_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/scoreboard_clear_arbiter.sv
// Round-robin arbiter sharing RF write / scoreboard clear ports among long-latency result sources.
// At most num_port_p grants per cycle, never two with the same destination id; port outputs are registered.
module scoreboard_clear_arbiter #(
  parameter int num_req_p         = 4,
  parameter int num_port_p        = 2,
  parameter int reg_els_p         = 32,
  parameter int data_width_p      = 32,
  parameter int x0_tied_to_zero_p = 0,
  parameter int id_width_lp       = $clog2(reg_els_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_ni,
  input  logic [num_req_p-1:0]                        v_i,
  input  logic [num_req_p-1:0][id_width_lp-1:0]       id_i,
  input  logic [num_req_p-1:0][data_width_p-1:0]      data_i,
  output logic [num_req_p-1:0]                        yumi_o,
  input  logic                                        stall_i,
  output logic [num_port_p-1:0]                       v_o,
  output logic [num_port_p-1:0][id_width_lp-1:0]      id_o,
  output logic [num_port_p-1:0][data_width_p-1:0]     data_o
);

  localparam int ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  logic [ptr_width_lp-1:0]                  rr_r;
  logic [ptr_width_lp-1:0]                  rr_n;
  logic [num_req_p-1:0]                     grant;
  logic [num_port_p-1:0]                    port_v;
  logic [num_port_p-1:0]                    port_wr;
  logic [num_port_p-1:0][id_width_lp-1:0]   port_id;
  logic [num_port_p-1:0][data_width_p-1:0]  port_data;

  // Scan from the pointer; a requester whose id matches an earlier grant this cycle waits.
  always_comb begin
    int   idx;
    int   cnt;
    int   last;
    logic clash;
    grant     = '0;
    port_v    = '0;
    port_id   = '0;
    port_data = '0;
    rr_n      = rr_r;
    idx       = 0;
    cnt       = 0;
    last      = 0;
    clash     = 1'b0;
    for (int j = 0; j < num_req_p; j++) begin
      idx = int'(rr_r) + j;
      if (idx >= num_req_p) idx = idx - num_req_p;
      clash = 1'b0;
      for (int k = 0; k < num_port_p; k++) begin
        if (port_v[k] && (port_id[k] == id_i[idx])) clash = 1'b1;
      end
      if (v_i[idx] && !stall_i && (cnt < num_port_p) && !clash) begin
        grant[idx]     = 1'b1;
        port_v[cnt]    = 1'b1;
        port_id[cnt]   = id_i[idx];
        port_data[cnt] = data_i[idx];
        cnt            = cnt + 1;
        last           = idx;
      end
    end
    if (cnt > 0) rr_n = (last == num_req_p - 1) ? '0 : ptr_width_lp'(last + 1);
  end

  // Writes to id 0 are still consumed when x0 is hardwired, but never reach the RF/scoreboard.
  always_comb begin
    port_wr = port_v;
    for (int k = 0; k < num_port_p; k++) begin
      if ((x0_tied_to_zero_p != 0) && (port_id[k] == '0)) port_wr[k] = 1'b0;
    end
  end

  assign yumi_o = reset_ni ? grant : '0;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_r   <= '0;
      v_o    <= '0;
      id_o   <= '0;
      data_o <= '0;
    end else begin
      rr_r <= rr_n;
      v_o  <= port_wr;
      for (int k = 0; k < num_port_p; k++) begin
        if (port_v[k]) begin
          id_o[k]   <= port_id[k];
          data_o[k] <= port_data[k];
        end
      end
    end
  end

  for (genvar j = 0; j < num_port_p; j++) begin : g_uniq_a
    for (genvar k = j + 1; k < num_port_p; k++) begin : g_uniq_b
      a_unique_id: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(v_o[j] && v_o[k] && (id_o[j] == id_o[k])));
    end
  end

endmodule
